led_blink_scheduler: RTL and testbench
======================================

# led_blink_scheduler

Time-shares a single status LED between NUM_REQ requesters, each asking for a burst of N blinks. Requests are arbitrated round-robin. The granted burst is played with fixed on/off phase lengths derived from a tick counter, followed by a dark gap so consecutive bursts stay distinguishable. The block sits between status sources (error flags, heartbeat, UART activity) and the board LED pin, replacing free-running per-LED blink counters.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- BLINK_W, 4: width of each blink-count field.
- TICKS_PER_PHASE, 50000000: clk cycles per ON, OFF and GAP phase (0.5 s at 100 MHz); must be ≥1.
- CNT_W, 32: phase timer width; must hold TICKS_PER_PHASE-1.
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level; held high until that requester's done pulse.
- blinks  input  NUM_REQ*BLINK_W  blink count per requester; requester i occupies bits [i*BLINK_W +: BLINK_W]; sampled at grant.
- grant  output  NUM_REQ  one-hot, registered; high for the whole service of the winner.
- done  output  NUM_REQ  one-cycle pulse to the served requester at the end of its burst.
- led_out  output  1  registered LED drive, 1 = lit.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, ON, OFF, DONE, GAP. Timer counts 0..TICKS_PER_PHASE-1 in ON, OFF and GAP, and is cleared on every state change.
- Registers: rr_ptr holds the highest-priority index; remaining holds the blink count still to play.
- IDLE: led_out 0, grant 0.
  - If any req bit is high, the winner w is the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - On that edge: grant[w] is set, remaining is loaded with blinks[w], and the state goes to DONE if blinks[w] is 0, otherwise to ON.
- ON: led_out 1. When the timer reaches TICKS_PER_PHASE-1: decrement remaining and go to OFF.
- OFF: led_out 0. When the timer reaches TICKS_PER_PHASE-1: go to DONE if remaining is 0, otherwise to ON.
- DONE: exactly one cycle.
  - done[w] is 1 and grant[w] is still 1.
  - rr_ptr is set to (w+1) mod NUM_REQ.
  - Next state is GAP.
- GAP: led_out 0, grant 0. When the timer reaches TICKS_PER_PHASE-1: go to IDLE.
- Changes to req or blinks during service are ignored. The latched count is used and the burst always completes.
- A req still high when IDLE is re-entered is a new request and is arbitrated normally.
- Reset, asynchronous, at any time:
  - State goes to IDLE; rr_ptr, timer and remaining go to 0.
  - grant, done, led_out and busy go to 0.
  - An in-flight burst is aborted with no done pulse.

## Timing
- Grant latency is 1 cycle: req seen high in IDLE at edge k gives grant and the first ON cycle from edge k.
- led_out rises on the same edge as grant.
- Service length for a count of n is 2·n·T + 1 + T cycles (T = TICKS_PER_PHASE) from grant to IDLE. For n = 0 it is 1 + T cycles.
- Minimum spacing between two grants is therefore service length + 1, because IDLE lasts one cycle.
- At most one grant bit and at most one done bit are ever high. done is always a subset of grant.
- Arithmetic: remaining is BLINK_W bits, so the maximum burst is 2^BLINK_W-1 blinks.
  - Timer comparison is equality against TICKS_PER_PHASE-1.
  - TICKS_PER_PHASE = 1 gives single-cycle phases.

## Test plan
(TICKS_PER_PHASE=4, NUM_REQ=4, BLINK_W=4 unless noted.)
- Reset: hold reset_n 0 with req=4'b1111 → all outputs 0. Release reset, req=4'b0001, blinks[0]=2:
  - grant=4'b0001 on the first edge.
  - led_out high for cycles 0-3 and 8-11, low for 4-7 and 12-15.
  - done[0] at cycle 16, grant drops at 17, busy drops at 21.
- Round-robin: req=4'b1111 held continuously, all counts 1 → grants in order 0,1,2,3,0, each grant 14 cycles after the previous one.
- Zero count: blinks[2]=0, req=4'b0100 → grant and done[2] on the same cycle, led_out stays 0 throughout, IDLE after 5 cycles.
- Mid-service changes: after grant, drop req[1] and change blinks[1] from 3 to 1 → exactly 3 blinks, then done[1].
- Reset mid-burst: assert reset_n=0 during the second ON phase → led_out, grant and busy are 0 immediately with no done pulse. After release, the next grant starts from rr_ptr=0.
- Maximum count: blinks[3]=15 with TICKS_PER_PHASE=1 → 15 one-cycle pulses on led_out, then done[3] at cycle 30.

Source files
------------

// File: rtl/led_blink_scheduler.sv
// Time-shares one status LED between NUM_REQ requesters: round-robin grant, then a
// burst of N equal on/off phases followed by a dark gap before the next grant.
module led_blink_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int BLINK_W         = 4,
    parameter int TICKS_PER_PHASE = 50000000,
    parameter int CNT_W           = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BLINK_W-1:0] blinks,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       led_out,
    output logic                       busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_PHASE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE,
        S_GAP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cur_idx;
    logic [CNT_W-1:0]   timer;
    logic [BLINK_W-1:0] remaining;

    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic [IDX_W:0]     cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic [BLINK_W-1:0] win_blinks;
    logic [BLINK_W-1:0] blink_arr [NUM_REQ];
    logic               phase_end;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign blink_arr[g] = blinks[g*BLINK_W +: BLINK_W];
    end

    // First set request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_valid && req[cand[IDX_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;
    assign win_blinks = blink_arr[win_idx];
    assign phase_end  = (timer == LAST_TICK);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cur_idx   <= '0;
            timer     <= '0;
            remaining <= '0;
            grant     <= '0;
            done      <= '0;
            led_out   <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        grant     <= win_onehot;
                        cur_idx   <= win_idx;
                        remaining <= win_blinks;
                        timer     <= '0;
                        if (win_blinks == '0) begin
                            state <= S_DONE;
                            done  <= win_onehot;
                        end else begin
                            state   <= S_ON;
                            led_out <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (phase_end) begin
                        remaining <= remaining - BLINK_W'(1);
                        state     <= S_OFF;
                        led_out   <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (phase_end) begin
                        timer <= '0;
                        if (remaining == '0) begin
                            state <= S_DONE;
                            done  <= grant;
                        end else begin
                            state   <= S_ON;
                            led_out <= 1'b1;
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Served requester drops to lowest priority for the next round.
                    rr_ptr <= (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);
                    grant  <= '0;
                    timer  <= '0;
                    state  <= S_GAP;
                end
                S_GAP: begin
                    if (phase_end) begin
                        timer <= '0;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    grant   <= '0;
                    led_out <= 1'b0;
                    timer   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: directed scenarios plus random traffic, compared each
// cycle against a service-timeline model (cycle offset since grant -> expected outputs).
module tb_led_blink_scheduler;

    localparam int NR = 4;
    localparam int BW = 4;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NR-1:0] req, req1;
    logic [NR*BW-1:0] blinks, blinks1;
    logic [NR-1:0] grant, done, grant1, done1;
    logic          led_out, busy, led_out1, busy1;

    led_blink_scheduler #(.NUM_REQ(NR), .BLINK_W(BW), .TICKS_PER_PHASE(T), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .blinks(blinks),
        .grant(grant), .done(done), .led_out(led_out), .busy(busy)
    );

    led_blink_scheduler #(.NUM_REQ(NR), .BLINK_W(BW), .TICKS_PER_PHASE(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req1), .blinks(blinks1),
        .grant(grant1), .done(done1), .led_out(led_out1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: a service is a timeline of 2nT blink cycles, one done cycle, T gap cycles.
    logic m_active = 1'b0;
    int   m_w = 0, m_n = 0, m_c = 0, m_rr = 0;
    logic auto_drop = 1'b1;
    logic [BW-1:0] exp_q[$];

    function automatic int svc_len(int n);
        return 2*n*T + 1 + T;
    endfunction

    function automatic logic [NR-1:0] exp_grant();
        return (m_active && m_c <= 2*m_n*T) ? NR'(1 << m_w) : '0;
    endfunction

    function automatic logic [NR-1:0] exp_done();
        return (m_active && m_c == 2*m_n*T) ? NR'(1 << m_w) : '0;
    endfunction

    function automatic logic exp_led();
        return m_active && (m_c < 2*m_n*T) && ((m_c / T) % 2 == 0);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_c      = 0;
        m_rr     = 0;
    endtask

    task automatic model_edge();
        logic found;
        found = 1'b0;
        if (!m_active) begin
            for (int i = 0; i < NR; i++) begin
                int j;
                j = (m_rr + i) % NR;
                if (!found && req[j]) begin
                    found    = 1'b1;
                    m_w      = j;
                    m_n      = int'(blinks[j*BW +: BW]);
                    m_c      = 0;
                    m_active = 1'b1;
                end
            end
        end else begin
            m_c++;
            if (m_c == 2*m_n*T + 1) m_rr = (m_w + 1) % NR;
            if (m_c == svc_len(m_n)) m_active = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'(0));
        check({tag, "_done"},  32'(done),  32'(0));
        check({tag, "_led"},   32'(led_out), 32'(0));
        check({tag, "_busy"},  32'(busy),  32'(0));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("grant", 32'(grant),   32'(exp_grant()));
        check("done",  32'(done),    32'(exp_done()));
        check("led",   32'(led_out), 32'(exp_led()));
        check("busy",  32'(busy),    32'(m_active));
        if (auto_drop) req = req & ~exp_done();
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] prev_grant;
        int last_grant_cyc;
        int rises;
        logic prev_led;

        // Reset with all requests asserted: everything stays dark.
        reset_n = 1'b0;
        req     = 4'b1111;
        req1    = 4'b1111;
        blinks  = 16'h2222;
        blinks1 = 16'h1111;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_grant1", 32'(grant1), 32'(0));
        check("reset_led1",   32'(led_out1), 32'(0));
        check("reset_busy1",  32'(busy1),  32'(0));
        req1 = '0;

        // Single burst of 2 from requester 0.
        @(negedge clk);
        req     = 4'b0001;
        blinks  = 16'h0002;
        reset_n = 1'b1;
        run_cycles(24);

        // Round-robin with every requester held high, one blink each.
        pulse_reset();
        auto_drop = 1'b0;
        req    = 4'b1111;
        blinks = 16'h1111;
        exp_q  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        prev_grant = '0;
        last_grant_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (grant != '0 && prev_grant == '0) begin
                if (exp_q.size() > 0) begin
                    check("rr_order", 32'(grant), 32'(1 << exp_q.pop_front()));
                end
                if (last_grant_cyc >= 0) check("rr_spacing", 32'(cyc - last_grant_cyc), 32'(14));
                last_grant_cyc = cyc;
            end
            prev_grant = grant;
        end
        check("rr_all_seen", 32'(exp_q.size()), 32'(0));
        req = '0;
        auto_drop = 1'b1;
        run_cycles(15);

        // Zero-count request: done with the grant, LED never lit.
        req    = 4'b0100;
        blinks = 16'h0000;
        run_cycles(8);

        // Request and count changed mid-service: latched count of 3 plays out.
        req    = 4'b0010;
        blinks = 16'h0030;
        step();
        req    = '0;
        blinks = 16'h0010;
        rises  = 0;
        prev_led = led_out;
        for (int k = 0; k < 32; k++) begin
            step();
            if (led_out && !prev_led) rises++;
            prev_led = led_out;
        end
        check("midsvc_blinks", 32'(rises + 1), 32'(3));

        // Asynchronous reset during the second ON phase.
        req    = 4'b0100;
        blinks = 16'h0200;
        step();
        for (int k = 0; k < 40 && m_c < 2*T + 1; k++) step();
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        reset_n = 1'b1;
        req    = 4'b1010;
        blinks = 16'h1010;
        step();
        check("after_abort_winner", 32'(grant), 32'(4'b0010));
        run_cycles(40);

        // Random traffic: requesters hold until served, counts churn freely.
        for (int k = 0; k < 700; k++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
                if ($urandom_range(0, 3) == 0) blinks[i*BW +: BW] = BW'($urandom_range(0, 3));
            end
        end
        req = '0;
        run_cycles(40);

        // Maximum count with single-cycle phases on the second instance.
        req1    = 4'b1000;
        blinks1 = 16'hF000;
        for (int c = 0; c < 34; c++) begin
            @(posedge clk);
            cyc++;
            #1;
            check("max_led",   32'(led_out1), 32'((c < 30) && (c % 2 == 0)));
            check("max_done",  32'(done1),    32'((c == 30) ? 4'b1000 : 4'b0000));
            check("max_grant", 32'(grant1),   32'((c <= 30) ? 4'b1000 : 4'b0000));
            check("max_busy",  32'(busy1),    32'(c <= 31));
            if (c == 30) req1 = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
